trn_tx_arb: RTL and testbench
=============================

// Module: trn_tx_arb
// PURPOSE
//  Arbitrates the PCIe endpoint TRN tx interface between NREQ DMA engines (tx, rx, irq/cpl).
//  Each engine raises req_ep, is granted my_trn, and then drives the TLP with drv_ep high.
//  Round-robin grant, held until the owner releases; TRN tx signals are muxed from the owner.
//  Sits between the tx/rx engine tops and the endpoint core.
// PARAMETERS
//  NREQ      2     number of requesters (2..4)
//  IW        1     grant index width, clog2(NREQ), min 1
//  WDOG_MAX  1024  idle-hold timeout in cycles (used only with TRN_ARB_WDOG_EN)
// PORTS
//  clk             in   1        pcie user clock
//  rst_n           in   1        asynchronous reset, active low
//  req_ep          in   NREQ     per-requester request
//  drv_ep          in   NREQ     per-requester "driving TRN" (TLP in flight)
//  my_trn          out  NREQ     one-hot grant
//  r_trn_td        in   NREQ*64  per-requester data, requester i at [64i+:64]
//  r_trn_trem_n    in   NREQ*8   per-requester remainder
//  r_trn_tsof_n    in   NREQ     per-requester sof
//  r_trn_teof_n    in   NREQ     per-requester eof
//  r_trn_tsrc_rdy_n in  NREQ     per-requester src_rdy
//  r_trn_tdst_rdy_n out NREQ     per-requester dst_rdy, = trn_tdst_rdy_n | ~my_trn[i]
//  trn_td          out  64       to endpoint
//  trn_trem_n      out  8        to endpoint
//  trn_tsof_n      out  1        to endpoint
//  trn_teof_n      out  1        to endpoint
//  trn_tsrc_rdy_n  out  1        to endpoint
//  trn_tdst_rdy_n  in   1        from endpoint
//  gnt_id          out  IW       index of current/last owner
//  proto_err       out  1        sticky: drv_ep seen from a non-owner
//  wdog_to         out  1        one-cycle pulse on watchdog revoke
// BEHAVIOUR
//  Reset: my_trn=0, gnt_id=0, rr pointer=0, proto_err=0, wdog_to=0, state IDLE.
//  FSM (registered): IDLE -> GRANT -> RELEASE -> IDLE.
//   IDLE: if any req_ep, select first requester at/after rr pointer (cyclic);
//     next cycle my_trn[sel]=1, gnt_id=sel -> GRANT. Grant latency: 1 clk after req_ep.
//   GRANT: held while req_ep[gnt] | drv_ep[gnt]. Dropping req while drv high does not
//     release. When both low: my_trn=0 next cycle, rr pointer = gnt_id+1 mod NREQ -> RELEASE.
//   RELEASE: one dead cycle, no grant (no two drivers in consecutive cycles) -> IDLE.
//  Back-to-back: a requester re-raising req while others wait is served after them.
//  Simultaneous requests: lowest index at/after rr pointer wins; others hold req and wait.
//  Mux: outputs select requester gnt_id while my_trn!=0; otherwise trn_td=0,
//   trn_trem_n=8'hFF, tsof_n=teof_n=tsrc_rdy_n=1. Combinational, no added latency.
//  r_trn_tdst_rdy_n of non-owners forced high.
//  proto_err: set when drv_ep[i]=1 and my_trn[i]=0 (RELEASE included); cleared only by reset.
//  Reset mid-TLP: grant dropped asynchronously, outputs idle; no TLP completion attempted.
// CONFIGURATION
//  TRN_ARB_WDOG_EN defined: counter clears on grant and whenever drv_ep[gnt]=1;
//   increments in GRANT while drv_ep[gnt]=0; at WDOG_MAX-1 the grant is revoked
//   (-> RELEASE, rr advances), wdog_to pulses 1 cycle. Never revokes with drv_ep high.
//  Undefined: no counter, wdog_to tied 0, grant held indefinitely.
// TESTING
//  Only req_ep[0] at cycle 10 -> my_trn=01 at cycle 11; drop at 20 -> my_trn=00 at 21.
//  req_ep=11 same cycle after reset -> grant 0; on release + dead cycle -> grant 1, gnt_id=1.
//  Owner 1 drops req while drv_ep[1]=1 for 5 clks -> grant held until drv low, then released.
//  TLP of 4 beats from owner 0, trn_tdst_rdy_n toggling -> trn_td matches r_trn_td[63:0]
//   each beat, r_trn_tdst_rdy_n[1] stays 1.
//  drv_ep[1]=1 while owner is 0 -> proto_err=1 next cycle, stays 1 until rst_n low.
//  WDOG_EN, WDOG_MAX=8: owner 0 holds req, drv low -> revoked after 8 clks, wdog_to pulse,
//   waiting requester 1 granted 2 cycles later.

Source files
------------

// File: rtl/trn_tx_arb_if.sv
// TRN tx bundle between the DMA engines, the arbiter and the endpoint core.
// slave: arbiter view; master: the requester/endpoint side that drives it.
interface trn_tx_arb_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req_ep;
  logic [NREQ-1:0]    drv_ep;
  logic [NREQ-1:0]    my_trn;
  logic [NREQ*64-1:0] r_trn_td;
  logic [NREQ*8-1:0]  r_trn_trem_n;
  logic [NREQ-1:0]    r_trn_tsof_n;
  logic [NREQ-1:0]    r_trn_teof_n;
  logic [NREQ-1:0]    r_trn_tsrc_rdy_n;
  logic [NREQ-1:0]    r_trn_tdst_rdy_n;
  logic [63:0]        trn_td;
  logic [7:0]         trn_trem_n;
  logic               trn_tsof_n;
  logic               trn_teof_n;
  logic               trn_tsrc_rdy_n;
  logic               trn_tdst_rdy_n;

  modport slave (
    input  req_ep, drv_ep, r_trn_td, r_trn_trem_n, r_trn_tsof_n, r_trn_teof_n,
           r_trn_tsrc_rdy_n, trn_tdst_rdy_n,
    output my_trn, r_trn_tdst_rdy_n, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n,
           trn_tsrc_rdy_n
  );

  modport master (
    output req_ep, drv_ep, r_trn_td, r_trn_trem_n, r_trn_tsof_n, r_trn_teof_n,
           r_trn_tsrc_rdy_n, trn_tdst_rdy_n,
    input  my_trn, r_trn_tdst_rdy_n, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n,
           trn_tsrc_rdy_n
  );
endinterface

// File: rtl/trn_tx_arb.sv
// Round-robin owner arbiter for the TRN tx port: grant 1 clk after req, held while req|drv, one dead cycle on release.
// Endpoint dst_rdy reaches only the owner; defining TRN_ARB_WDOG_EN adds the idle-hold watchdog revoke.
module trn_tx_arb #(
  parameter int NREQ     = 2,
  parameter int IW       = (NREQ > 2) ? 2 : 1,
  parameter int WDOG_MAX = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  trn_tx_arb_if.slave   bus,
  output logic [IW-1:0] gnt_id,
  output logic          proto_err,
  output logic          wdog_to
);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_RELEASE} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] my_trn_q, my_trn_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   sel;
  logic            perr_q, perr_d;
  logic            wto_q, wto_d;
  logic            any_req;
  logic            own_req;
  logic            own_drv;
  logic            wdog_hit;

  if (NREQ < 2 || NREQ > 4 || IW < 1 || WDOG_MAX < 2) begin : g_bad_param
    $error("trn_tx_arb: unsupported parameter set");
  end

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] v);
    if (v == IW'(NREQ - 1)) return '0;
    return v + 1'b1;
  endfunction

  assign own_req = bus.req_ep[gnt_q];
  assign own_drv = bus.drv_ep[gnt_q];

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin : rr_pick
    logic [IW-1:0] idx;
    any_req = 1'b0;
    sel     = rr_q;
    idx     = rr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!any_req && bus.req_ep[idx]) begin
        any_req = 1'b1;
        sel     = idx;
      end
      idx = next_idx(idx);
    end
  end

`ifdef TRN_ARB_WDOG_EN
  localparam int CW = (WDOG_MAX > 2) ? $clog2(WDOG_MAX) : 1;

  logic [CW-1:0] wcnt_q, wcnt_d;

  assign wdog_hit = (wcnt_q == CW'(WDOG_MAX - 1));
  assign wcnt_d   = (state_q == ST_GRANT && own_req && !own_drv && !wdog_hit) ?
                    wcnt_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt_q <= '0;
    else        wcnt_q <= wcnt_d;
  end
`else
  assign wdog_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    my_trn_d = my_trn_q;
    gnt_d    = gnt_q;
    rr_d     = rr_q;
    wto_d    = 1'b0;
    perr_d   = perr_q | (|(bus.drv_ep & ~my_trn_q));
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          my_trn_d = NREQ'(1) << sel;
          gnt_d    = sel;
          state_d  = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A TLP in flight (drv high) always keeps the grant, watchdog or not.
        if ((!own_req || wdog_hit) && !own_drv) begin
          my_trn_d = '0;
          rr_d     = next_idx(gnt_q);
          wto_d    = own_req;
          state_d  = ST_RELEASE;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      my_trn_q <= '0;
      gnt_q    <= '0;
      rr_q     <= '0;
      perr_q   <= 1'b0;
      wto_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      my_trn_q <= my_trn_d;
      gnt_q    <= gnt_d;
      rr_q     <= rr_d;
      perr_q   <= perr_d;
      wto_q    <= wto_d;
    end
  end

  always_comb begin
    bus.trn_td         = '0;
    bus.trn_trem_n     = 8'hFF;
    bus.trn_tsof_n     = 1'b1;
    bus.trn_teof_n     = 1'b1;
    bus.trn_tsrc_rdy_n = 1'b1;
    if (|my_trn_q) begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_q == IW'(i)) begin
          bus.trn_td         = bus.r_trn_td[64*i +: 64];
          bus.trn_trem_n     = bus.r_trn_trem_n[8*i +: 8];
          bus.trn_tsof_n     = bus.r_trn_tsof_n[i];
          bus.trn_teof_n     = bus.r_trn_teof_n[i];
          bus.trn_tsrc_rdy_n = bus.r_trn_tsrc_rdy_n[i];
        end
      end
    end
  end

  assign bus.r_trn_tdst_rdy_n = {NREQ{bus.trn_tdst_rdy_n}} | ~my_trn_q;
  assign bus.my_trn           = my_trn_q;
  assign gnt_id               = gnt_q;
  assign proto_err            = perr_q;
  assign wdog_to              = wto_q;

endmodule

// File: tb/tb_trn_tx_arb.sv
// Directed and randomized bench for trn_tx_arb against an owner/round-robin reference model.
module tb_trn_tx_arb;
  localparam int N    = 2;
  localparam int WMAX = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:0] gnt_id;
  logic       proto_err;
  logic       wdog_to;

  always #5 clk = ~clk;

  trn_tx_arb_if #(.NREQ(N)) bus();

  trn_tx_arb #(.NREQ(N), .IW(1), .WDOG_MAX(WMAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .gnt_id    (gnt_id),
    .proto_err (proto_err),
    .wdog_to   (wdog_to)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the port, whether we sit in the dead cycle, and the rr pointer.
  int m_own, m_rr, m_gid, m_cnt;
  bit m_dead, m_perr, m_wto;

  int ph[N];
  int hold[N];
  int beats[N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_rr = 0; m_gid = 0; m_cnt = 0;
    m_dead = 0; m_perr = 0; m_wto = 0;
  endtask

  function automatic logic [N-1:0] exp_trn();
    return (m_own >= 0) ? N'(1) << m_own : '0;
  endfunction

  task automatic model_next();
    logic [N-1:0] rq, dv;
    rq = bus.req_ep;
    dv = bus.drv_ep;
    for (int i = 0; i < N; i++)
      if (dv[i] && m_own != i) m_perr = 1;
    m_wto = 0;
    if (m_own >= 0) begin
      if (dv[m_own]) m_cnt = 0;
      else if (!rq[m_own]) begin
        m_rr = (m_own + 1) % N; m_own = -1; m_dead = 1;
      end else begin
`ifdef TRN_ARB_WDOG_EN
        if (m_cnt == WMAX - 1) begin
          m_wto = 1; m_rr = (m_own + 1) % N; m_own = -1; m_dead = 1;
        end else m_cnt++;
`endif
      end
    end else if (m_dead) begin
      m_dead = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (m_own < 0 && rq[c]) begin
          m_own = c; m_gid = c; m_cnt = 0;
        end
      end
    end
  endtask

  task automatic check_regs(input string ctx);
    chk({ctx, ".my_trn"}, bus.my_trn, exp_trn());
    chk({ctx, ".gnt_id"}, gnt_id, 64'(m_gid));
    chk({ctx, ".proto_err"}, proto_err, m_perr);
    chk({ctx, ".wdog_to"}, wdog_to, m_wto);
  endtask

  task automatic check_mux(input string ctx);
    logic [63:0]  etd;
    logic [7:0]   etrem;
    logic         es, ee, er;
    logic [N-1:0] edst;
    etd = '0; etrem = 8'hFF; es = 1; ee = 1; er = 1;
    if (m_own >= 0) begin
      etd   = 64'(bus.r_trn_td >> (64 * m_own));
      etrem = 8'(bus.r_trn_trem_n >> (8 * m_own));
      es    = bus.r_trn_tsof_n[m_own];
      ee    = bus.r_trn_teof_n[m_own];
      er    = bus.r_trn_tsrc_rdy_n[m_own];
    end
    for (int i = 0; i < N; i++) edst[i] = (m_own == i) ? bus.trn_tdst_rdy_n : 1'b1;
    chk({ctx, ".trn_td"}, bus.trn_td, etd);
    chk({ctx, ".trn_trem_n"}, bus.trn_trem_n, etrem);
    chk({ctx, ".tsof_n"}, bus.trn_tsof_n, es);
    chk({ctx, ".teof_n"}, bus.trn_teof_n, ee);
    chk({ctx, ".tsrc_rdy_n"}, bus.trn_tsrc_rdy_n, er);
    chk({ctx, ".r_tdst_rdy_n"}, bus.r_trn_tdst_rdy_n, edst);
  endtask

  task automatic tick(input string ctx);
    #1;
    check_mux(ctx);
    model_next();
    @(posedge clk);
    #1;
    check_regs(ctx);
  endtask

  task automatic set_idle();
    bus.req_ep = '0; bus.drv_ep = '0;
    bus.r_trn_td = '0; bus.r_trn_trem_n = '1;
    bus.r_trn_tsof_n = '1; bus.r_trn_teof_n = '1; bus.r_trn_tsrc_rdy_n = '1;
    bus.trn_tdst_rdy_n = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst.async_my_trn", bus.my_trn, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_regs("rst");
    check_mux("rst");
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0]  td0;
    logic [N-1:0] rq, dv;

    rst_n = 1'b0;
    set_idle();
    model_reset();
    #12;
    do_reset();
    chk("rst.gnt_id", gnt_id, 0);
    chk("rst.trn_tsrc_rdy_n", bus.trn_tsrc_rdy_n, 1);

    // Single requester: 1 clk grant latency, 1 clk release.
    repeat (3) tick("t1.idle");
    bus.req_ep = 2'b01;
    tick("t1.req");
    chk("t1.grant_latency", bus.my_trn, 2'b01);
    repeat (5) tick("t1.hold");
    bus.req_ep = 2'b00;
    tick("t1.drop");
    chk("t1.released", bus.my_trn, 2'b00);
    tick("t1.dead");
    tick("t1.idle2");

    // Simultaneous requests straight after reset.
    do_reset();
    bus.req_ep = 2'b11;
    tick("t2.req");
    chk("t2.first_grant", bus.my_trn, 2'b01);
    chk("t2.first_id", gnt_id, 0);
    bus.req_ep = 2'b10;
    tick("t2.drop0");
    chk("t2.release", bus.my_trn, 2'b00);
    tick("t2.dead");
    chk("t2.dead_no_grant", bus.my_trn, 2'b00);
    tick("t2.second");
    chk("t2.second_grant", bus.my_trn, 2'b10);
    chk("t2.second_id", gnt_id, 1);

    // Owner 1 drops req while still driving.
    bus.drv_ep = 2'b10;
    bus.req_ep = 2'b00;
    for (int c = 0; c < 5; c++) begin
      tick("t3.drv_hold");
      chk("t3.still_owned", bus.my_trn, 2'b10);
    end
    bus.drv_ep = 2'b00;
    tick("t3.drv_drop");
    chk("t3.released", bus.my_trn, 2'b00);
    tick("t3.dead");
    tick("t3.idle");

    // Four-beat TLP from owner 0 with dst_rdy toggling.
    bus.req_ep = 2'b01;
    tick("t4.req");
    chk("t4.grant", bus.my_trn, 2'b01);
    for (int b = 0; b < 4; b++) begin
      bus.drv_ep = 2'b01;
      td0 = {$urandom, $urandom};
      bus.r_trn_td = {$urandom, $urandom, td0};
      bus.r_trn_trem_n = (b == 3) ? 16'hFF0F : 16'hFF00;
      bus.r_trn_tsof_n = {1'b1, (b != 0)};
      bus.r_trn_teof_n = {1'b1, (b != 3)};
      bus.r_trn_tsrc_rdy_n = 2'b10;
      bus.trn_tdst_rdy_n = b[0];
      #1;
      chk("t4.trn_td", bus.trn_td, td0);
      chk("t4.dst_rdy1", bus.r_trn_tdst_rdy_n[1], 1);
      chk("t4.dst_rdy0", bus.r_trn_tdst_rdy_n[0], b[0]);
      chk("t4.tsof_n", bus.trn_tsof_n, (b != 0));
      tick("t4.beat");
    end
    set_idle();
    tick("t4.end");
    chk("t4.released", bus.my_trn, 2'b00);
    tick("t4.dead");
    tick("t4.idle");

    // Non-owner drives: sticky protocol error until reset.
    bus.req_ep = 2'b01;
    tick("t5.req");
    bus.drv_ep = 2'b10;
    tick("t5.bad_drv");
    chk("t5.proto_set", proto_err, 1);
    bus.drv_ep = 2'b00;
    repeat (3) tick("t5.sticky");
    bus.req_ep = 2'b00;
    repeat (3) tick("t5.idle");
    chk("t5.proto_sticky", proto_err, 1);
    do_reset();
    chk("t5.proto_cleared", proto_err, 0);

    // Randomized protocol-compliant requesters.
    for (int i = 0; i < N; i++) begin ph[i] = 0; hold[i] = 0; beats[i] = 0; end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rq = '0; dv = '0;
      for (int i = 0; i < N; i++) begin
        if (ph[i] == 1 && bus.my_trn[i]) begin
          ph[i] = 2; hold[i] = $urandom_range(2); beats[i] = $urandom_range(6, 1);
        end
        if (ph[i] == 2) begin
          if (!bus.my_trn[i]) ph[i] = 0;
          else if (hold[i] > 0) begin hold[i]--; rq[i] = 1; end
          else if (beats[i] > 0) begin beats[i]--; dv[i] = 1; rq[i] = 1'($urandom_range(1)); end
          else ph[i] = 0;
        end else if (ph[i] == 1) rq[i] = 1;
        else if ($urandom_range(3) == 0) begin ph[i] = 1; rq[i] = 1; end
      end
      bus.req_ep = rq;
      bus.drv_ep = dv;
      bus.r_trn_td = {$urandom, $urandom, $urandom, $urandom};
      bus.r_trn_trem_n = 16'($urandom);
      bus.r_trn_tsof_n = 2'($urandom);
      bus.r_trn_teof_n = 2'($urandom);
      bus.r_trn_tsrc_rdy_n = 2'($urandom);
      bus.trn_tdst_rdy_n = 1'($urandom_range(1));
      tick("rnd");
    end
    chk("rnd.no_proto_err", proto_err, 0);

`ifdef TRN_ARB_WDOG_EN
    // Idle-holding owner gets revoked; the waiting requester follows after the dead cycle.
    do_reset();
    bus.req_ep = 2'b01;
    tick("wd.req");
    chk("wd.grant", bus.my_trn, 2'b01);
    bus.req_ep = 2'b11;
    for (int k = 1; k <= WMAX; k++) begin
      tick("wd.count");
      chk("wd.my_trn", bus.my_trn, (k < WMAX) ? 2'b01 : 2'b00);
      chk("wd.pulse", wdog_to, (k == WMAX));
    end
    tick("wd.dead");
    chk("wd.pulse_end", wdog_to, 0);
    chk("wd.dead_no_grant", bus.my_trn, 2'b00);
    tick("wd.next");
    chk("wd.next_grant", bus.my_trn, 2'b10);
    chk("wd.next_id", gnt_id, 1);
    bus.req_ep = 2'b00;
    repeat (3) tick("wd.end");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
